genius_sequencer: RTL and testbench

Parametrised Genius/Simon game engine that owns the whole round loop. It generates the colour sequence with an internal LFSR, stores it in internal memory, and plays it back on the LEDs with fixed on/off timing. It then checks player presses with an optional input timeout and reports score, victory and defeat. It sits between the board I/O (buttons, LEDs) and the score display, and replaces the external memory/counter datapath previously driven by the game controller FSM.

---
 rtl/genius_if.sv | 22 ++
 rtl/genius_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_genius_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/genius_if.sv
// Board-side bundle for genius_sequencer: game controls and buttons in, LEDs and score out.
interface genius_if #(
  parameter int NUM_LEDS   = 4,
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic [1:0]            difficulty;
  logic                  mode;
  logic [15:0]           seed;
  logic [NUM_LEDS-1:0]   player_input;
  logic [NUM_LEDS-1:0]   led;
  logic                  all_leds;
  logic                  victory;
  logic                  defeat;
  logic                  busy;
  logic [ADDR_WIDTH:0]   score;

  modport master (output start, difficulty, mode, seed, player_input,
                  input  led, all_leds, victory, defeat, busy, score);
  modport slave  (input  start, difficulty, mode, seed, player_input,
                  output led, all_leds, victory, defeat, busy, score);
endinterface

// File: rtl/genius_sequencer.sv
// Genius/Simon round engine: LFSR sequence generation, LED playback, press checking, scoring.
// Optional: define GENIUS_TIMEOUT_EN to make WAIT_INPUT lose after TIMEOUT_CYCLES without a press.
//
// state      | meaning
// IDLE       | waiting for start
// ADD_ITEM   | append one LFSR item to the sequence
// SHOW_ON    | lamp the current item for SHOW_CYCLES
// SHOW_OFF   | dark gap of GAP_CYCLES, then next item or hand over to player
// WAIT_INPUT | waiting for a fresh button press
// CHECK      | compare captured press with expected item
// ROUND_DONE | update score, finish game or grow sequence
// WIN / LOSE | one-cycle result pulse
module genius_sequencer #(
  parameter int NUM_LEDS       = 4,
  parameter int ADDR_WIDTH     = 6,
  parameter int SHOW_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  genius_if.slave bus
);
  localparam int CW    = $clog2(NUM_LEDS);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam int TMAX0 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMAX  = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_ADD_ITEM   = 4'd1;
  localparam logic [3:0] S_SHOW_ON    = 4'd2;
  localparam logic [3:0] S_SHOW_OFF   = 4'd3;
  localparam logic [3:0] S_WAIT_INPUT = 4'd4;
  localparam logic [3:0] S_CHECK      = 4'd5;
  localparam logic [3:0] S_ROUND_DONE = 4'd6;
  localparam logic [3:0] S_WIN        = 4'd7;
  localparam logic [3:0] S_LOSE       = 4'd8;

  logic [3:0]            state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [LW-1:0]         length_q, length_d;
  logic [LW-1:0]         target_q, target_d;
  logic [LW-1:0]         score_q, score_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] show_ptr_q, show_ptr_d;
  logic [ADDR_WIDTH-1:0] match_ptr_q, match_ptr_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [NUM_LEDS-1:0]   prev_in_q;
  logic [NUM_LEDS-1:0]   cap_q, cap_d;
  logic [CW-1:0]         mem_q [DEPTH];
  logic                  mem_we;

  logic [31:0]           target_raw;
  logic [LW-1:0]         target_sel;
  logic [NUM_LEDS-1:0]   show_onehot, match_onehot;
  logic                  press, last_show, last_match;

  assign target_raw   = 32'd8 << bus.difficulty;
  assign target_sel   = (target_raw > 32'(DEPTH)) ? LW'(DEPTH) : LW'(target_raw);
  assign show_onehot  = NUM_LEDS'(1) << mem_q[show_ptr_q];
  assign match_onehot = NUM_LEDS'(1) << mem_q[match_ptr_q];
  // A press is the first cycle any button goes down after all were released.
  assign press        = (|bus.player_input) && (prev_in_q == '0);
  assign last_show    = ({1'b0, show_ptr_q}  == length_q - LW'(1));
  assign last_match   = ({1'b0, match_ptr_q} == length_q - LW'(1));

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    length_d    = length_q;
    target_d    = target_q;
    score_d     = score_q;
    mode_d      = mode_q;
    show_ptr_d  = show_ptr_q;
    match_ptr_d = match_ptr_q;
    timer_d     = timer_q;
    cap_d       = cap_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        lfsr_d   = (bus.seed == 16'h0000) ? 16'h0001 : bus.seed;
        target_d = target_sel;
        mode_d   = bus.mode;
        length_d = '0;
        score_d  = '0;
        state_d  = S_ADD_ITEM;
      end
      S_ADD_ITEM: begin
        mem_we     = 1'b1;
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        length_d   = length_q + LW'(1);
        show_ptr_d = mode_q ? length_q[ADDR_WIDTH-1:0] : '0;
        timer_d    = TW'(SHOW_CYCLES - 1);
        state_d    = S_SHOW_ON;
      end
      S_SHOW_ON: if (timer_q == '0) begin
        timer_d = TW'(GAP_CYCLES - 1);
        state_d = S_SHOW_OFF;
      end else begin
        timer_d = timer_q - TW'(1);
      end
      S_SHOW_OFF: if (timer_q == '0) begin
        if (last_show) begin
          match_ptr_d = '0;
          timer_d     = TW'(TIMEOUT_CYCLES - 1);
          state_d     = S_WAIT_INPUT;
        end else begin
          show_ptr_d = show_ptr_q + ADDR_WIDTH'(1);
          timer_d    = TW'(SHOW_CYCLES - 1);
          state_d    = S_SHOW_ON;
        end
      end else begin
        timer_d = timer_q - TW'(1);
      end
      S_WAIT_INPUT: begin
        if (press) begin
          cap_d   = bus.player_input;
          state_d = S_CHECK;
        end
`ifdef GENIUS_TIMEOUT_EN
        else if (timer_q == '0) begin
          state_d = S_LOSE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
`endif
      end
      S_CHECK: if (cap_q != match_onehot) begin
        state_d = S_LOSE;
      end else if (last_match) begin
        state_d = S_ROUND_DONE;
      end else begin
        match_ptr_d = match_ptr_q + ADDR_WIDTH'(1);
        timer_d     = TW'(TIMEOUT_CYCLES - 1);
        state_d     = S_WAIT_INPUT;
      end
      S_ROUND_DONE: begin
        score_d = length_q;
        state_d = (length_q == target_q) ? S_WIN : S_ADD_ITEM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= 16'h0001;
      length_q    <= '0;
      target_q    <= '0;
      score_q     <= '0;
      mode_q      <= 1'b0;
      show_ptr_q  <= '0;
      match_ptr_q <= '0;
      timer_q     <= '0;
      prev_in_q   <= '0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      length_q    <= length_d;
      target_q    <= target_d;
      score_q     <= score_d;
      mode_q      <= mode_d;
      show_ptr_q  <= show_ptr_d;
      match_ptr_q <= match_ptr_d;
      timer_q     <= timer_d;
      prev_in_q   <= bus.player_input;
      cap_q       <= cap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[length_q[ADDR_WIDTH-1:0]] <= lfsr_q[CW-1:0];
  end

  assign bus.led      = (state_q == S_SHOW_ON) ? show_onehot : '0;
  assign bus.all_leds = (state_q == S_WIN) || (state_q == S_LOSE);
  assign bus.victory  = (state_q == S_WIN);
  assign bus.defeat   = (state_q == S_LOSE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.score    = score_q;
endmodule

// File: tb/tb_genius_sequencer.sv
// Directed bench for genius_sequencer: a game-level plan yields per-cycle expected outputs and stimulus.
module tb_genius_sequencer;
  localparam int NUM_LEDS       = 4;
  localparam int ADDR_WIDTH     = 6;
  localparam int SHOW_CYCLES    = 4;
  localparam int GAP_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int SW             = ADDR_WIDTH + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  genius_if #(.NUM_LEDS(NUM_LEDS), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  genius_sequencer #(
    .NUM_LEDS(NUM_LEDS), .ADDR_WIDTH(ADDR_WIDTH), .SHOW_CYCLES(SHOW_CYCLES),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic                start;
    logic [1:0]          diff;
    logic                mode;
    logic [15:0]         seed;
    logic [NUM_LEDS-1:0] pin;
    logic [NUM_LEDS-1:0] led;
    logic                all;
    logic                vic;
    logic                def;
    logic                busy;
    logic [SW-1:0]       score;
  } step_t;

  step_t       plan[$];
  int          seq[$];
  int          checks   = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          vic_seen = 0;
  int          def_seen = 0;
  logic [1:0]  g_diff   = 2'd0;
  logic        g_mode   = 1'b0;
  logic [15:0] g_seed   = 16'h0001;
  int          g_score  = 0;

  task automatic chk(input string name, input int at, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, at, act, exp);
    end
  endtask

  // Colour sequence straight from the LFSR rule: item = low bits, then advance.
  function automatic void gen_seq(input logic [15:0] seed);
    logic [15:0] l;
    l = (seed == 16'h0000) ? 16'h0001 : seed;
    seq.delete();
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) begin
      seq.push_back(int'(l % NUM_LEDS));
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end
  endfunction

  function automatic void push(input bit st, input int pin, input int led,
                               input bit busy, input bit vic, input bit def);
    step_t s;
    s.start = st;  s.diff = g_diff; s.mode = g_mode; s.seed = g_seed;
    s.pin   = NUM_LEDS'(pin);
    s.led   = NUM_LEDS'(led);
    s.busy  = busy; s.vic = vic; s.def = def; s.all = vic | def;
    s.score = SW'(g_score);
    plan.push_back(s);
  endfunction

  function automatic void plan_idle(input int n);
    for (int i = 0; i < n; i++) push(0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void plan_start();
    push(1, 0, 0, 0, 0, 0);
    g_score = 0;
  endfunction

  function automatic void plan_show(input int len);
    push(0, 0, 0, 1, 0, 0);
    for (int i = (g_mode ? len - 1 : 0); i < len; i++) begin
      for (int c = 0; c < SHOW_CYCLES; c++) push(0, 0, 1 << seq[i], 1, 0, 0);
      for (int c = 0; c < GAP_CYCLES; c++)  push(0, 0, 0, 1, 0, 0);
    end
  endfunction

  // One round of length len; a press at bad_idx uses bad_val and the game is lost there.
  function automatic void plan_round(input int len, input int delay, input int bad_idx, input int bad_val);
    plan_show(len);
    for (int i = 0; i < len; i++) begin
      for (int d = 0; d < delay; d++) push(0, 0, 0, 1, 0, 0);
      push(0, (i == bad_idx) ? bad_val : (1 << seq[i]), 0, 1, 0, 0);
      push(0, 0, 0, 1, 0, 0);
      if (i == bad_idx) begin
        push(0, 0, 0, 1, 0, 1);
        push(0, 0, 0, 0, 0, 0);
        return;
      end
    end
    push(0, 0, 0, 1, 0, 0);
    g_score = len;
  endfunction

  function automatic void plan_game(input int target, input int delay);
    plan_start();
    for (int len = 1; len <= target; len++) plan_round(len, delay, -1, 0);
    push(0, 0, 0, 1, 1, 0);
    push(0, 0, 0, 0, 0, 0);
  endfunction

  task automatic run_plan();
    step_t s;
    vic_seen = 0;
    def_seen = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(negedge clk);
      cyc++;
      chk("led",      cyc, 32'(bus.led),      32'(s.led));
      chk("busy",     cyc, 32'(bus.busy),     32'(s.busy));
      chk("victory",  cyc, 32'(bus.victory),  32'(s.vic));
      chk("defeat",   cyc, 32'(bus.defeat),   32'(s.def));
      chk("all_leds", cyc, 32'(bus.all_leds), 32'(s.all));
      chk("score",    cyc, 32'(bus.score),    32'(s.score));
      vic_seen += int'(bus.victory);
      def_seen += int'(bus.defeat);
      bus.start        = s.start;
      bus.difficulty   = s.diff;
      bus.mode         = s.mode;
      bus.seed         = s.seed;
      bus.player_input = s.pin;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_led"},      cyc, 32'(bus.led),      32'h0);
    chk({tag, "_all_leds"}, cyc, 32'(bus.all_leds), 32'h0);
    chk({tag, "_victory"},  cyc, 32'(bus.victory),  32'h0);
    chk({tag, "_defeat"},   cyc, 32'(bus.defeat),   32'h0);
    chk({tag, "_busy"},     cyc, 32'(bus.busy),     32'h0);
    chk({tag, "_score"},    cyc, 32'(bus.score),    32'h0);
  endtask

  initial begin
    bus.start = 1'b0; bus.difficulty = 2'd0; bus.mode = 1'b0;
    bus.seed = 16'h0001; bus.player_input = '0;

    for (int i = 0; i < 5; i++) begin
      bus.start        = 1'($urandom);
      bus.difficulty   = 2'($urandom);
      bus.mode         = 1'($urandom);
      bus.seed         = 16'($urandom);
      bus.player_input = NUM_LEDS'($urandom);
      @(negedge clk);
      chk_all_zero("reset");
    end
    bus.start = 1'b0; bus.player_input = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Full game, seed 1, difficulty 0: eight rounds then victory.
    g_seed = 16'h0001; g_diff = 2'd0; g_mode = 1'b0;
    gen_seq(g_seed);
    chk("model_item0", 0, 32'(1 << seq[0]), 32'h2);
    chk("model_item1", 0, 32'(1 << seq[1]), 32'h1);
    plan_idle(2);
    plan_game(8, 0);
    run_plan();
    chk("win_score",  cyc, 32'(bus.score), 32'd8);
    chk("win_pulses", cyc, 32'(vic_seen),  32'd1);
    chk("win_idle",   cyc, 32'(bus.busy),  32'd0);

    // Wrong colour in round 1, then a two-button press in round 1.
    plan_idle(1); plan_start(); plan_round(1, 0, 0, 4'b0001);
    run_plan();
    chk("lose_score",  cyc, 32'(bus.score), 32'd0);
    chk("lose_pulses", cyc, 32'(def_seen),  32'd1);
    plan_idle(1); plan_start(); plan_round(1, 3, 0, 4'b0011);
    run_plan();
    chk("multi_press_pulses", cyc, 32'(def_seen), 32'd1);

    // Newest-only playback: full sequence still required; lose in round 3.
    g_mode = 1'b1;
    plan_idle(1); plan_start();
    plan_round(1, 0, -1, 0); plan_round(2, 1, -1, 0); plan_round(3, 0, 1, 4'b1000);
    run_plan();
    chk("mode1_score", cyc, 32'(bus.score), 32'd2);
    chk("mode1_lose",  cyc, 32'(def_seen),  32'd1);

`ifdef GENIUS_TIMEOUT_EN
    g_mode = 1'b0;
    plan_idle(1); plan_start(); plan_show(1);
    for (int i = 0; i < TIMEOUT_CYCLES; i++) push(0, 0, 0, 1, 0, 0);
    push(0, 0, 0, 1, 0, 1);
    push(0, 0, 0, 0, 0, 0);
    run_plan();
    chk("timeout_defeat", cyc, 32'(def_seen), 32'd1);
    plan_idle(1); plan_start();
    plan_round(1, TIMEOUT_CYCLES - 1, -1, 0);
    plan_round(2, 0, 0, 4'b1111);
    run_plan();
    chk("last_cycle_press_score", cyc, 32'(bus.score), 32'd1);
`else
    g_mode = 1'b0;
    plan_idle(1); plan_start();
    plan_round(1, 1000, -1, 0);
    plan_round(2, 0, 0, 4'b1111);
    run_plan();
    chk("no_timeout_score", cyc, 32'(bus.score), 32'd1);
    chk("no_timeout_lose",  cyc, 32'(def_seen),  32'd1);
`endif

    // Difficulty 1 with another seed: sixteen rounds, newest-only playback.
    g_seed = 16'hACE1; g_diff = 2'd1; g_mode = 1'b1;
    gen_seq(g_seed);
    plan_idle(1); plan_game(16, 0);
    run_plan();
    chk("diff1_score",  cyc, 32'(bus.score), 32'd16);
    chk("diff1_pulses", cyc, 32'(vic_seen),  32'd1);

    // Asynchronous reset during round 3 playback.
    g_seed = 16'h0001; g_diff = 2'd0; g_mode = 1'b0;
    gen_seq(g_seed);
    plan_idle(1); plan_start();
    plan_round(1, 0, -1, 0); plan_round(2, 0, -1, 0);
    push(0, 0, 0, 1, 0, 0);
    push(0, 0, 1 << seq[0], 1, 0, 0);
    push(0, 0, 1 << seq[0], 1, 0, 0);
    run_plan();
    chk("pre_reset_led", cyc, 32'(bus.led), 32'h2);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midgame_reset");
    repeat (2) @(negedge clk);
    chk_all_zero("held_reset");
    rst_n = 1'b1;
    g_score = 0;

    // Restart from round 1 with a zero seed (treated as seed 1).
    g_seed = 16'h0000;
    gen_seq(g_seed);
    plan_idle(2); plan_game(8, 1);
    run_plan();
    chk("restart_score",  cyc, 32'(bus.score), 32'd8);
    chk("restart_pulses", cyc, 32'(vic_seen),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
